// File: rtl/axi4_write_arbiter.sv
// ============================================================================
// Module      : axi4_write_arbiter
// Description : Two-master to one-slave AXI4 write-channel arbiter, round-robin,
//               one write transaction (AW, W burst, B) in flight at a time.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_write_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 11
) (
    input  logic                clk,
    input  logic                rst,
    // master 0
    input  logic [ID_W-1:0]     m0_aw_id,
    input  logic [ADDR_W-1:0]   m0_aw_addr,
    input  logic [7:0]          m0_aw_len,
    input  logic [2:0]          m0_aw_size,
    input  logic [1:0]          m0_aw_burst,
    input  logic                m0_aw_valid,
    output logic                m0_aw_ready,
    input  logic [DATA_W-1:0]   m0_w_data,
    input  logic [DATA_W/8-1:0] m0_w_strb,
    input  logic                m0_w_last,
    input  logic                m0_w_valid,
    output logic                m0_w_ready,
    output logic [ID_W-1:0]     m0_b_id,
    output logic [1:0]          m0_b_resp,
    output logic                m0_b_valid,
    input  logic                m0_b_ready,
    // master 1
    input  logic [ID_W-1:0]     m1_aw_id,
    input  logic [ADDR_W-1:0]   m1_aw_addr,
    input  logic [7:0]          m1_aw_len,
    input  logic [2:0]          m1_aw_size,
    input  logic [1:0]          m1_aw_burst,
    input  logic                m1_aw_valid,
    output logic                m1_aw_ready,
    input  logic [DATA_W-1:0]   m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    input  logic                m1_w_last,
    input  logic                m1_w_valid,
    output logic                m1_w_ready,
    output logic [ID_W-1:0]     m1_b_id,
    output logic [1:0]          m1_b_resp,
    output logic                m1_b_valid,
    input  logic                m1_b_ready,
    // shared slave
    output logic [ID_W-1:0]     s_aw_id,
    output logic [ADDR_W-1:0]   s_aw_addr,
    output logic [7:0]          s_aw_len,
    output logic [2:0]          s_aw_size,
    output logic [1:0]          s_aw_burst,
    output logic                s_aw_valid,
    input  logic                s_aw_ready,
    output logic [DATA_W-1:0]   s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    output logic                s_w_last,
    output logic                s_w_valid,
    input  logic                s_w_ready,
    input  logic [ID_W-1:0]     s_b_id,
    input  logic [1:0]          s_b_resp,
    input  logic                s_b_valid,
    output logic                s_b_ready,
    // monitor
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       rr_last_q, rr_last_d;   // 1: master 1 was served last
    logic [7:0] len_q, len_d;
    logic [7:0] beat_q, beat_d;
    logic       err_len_q, err_len_d;

    logic sel;
    logic active;
    logic aw_hs, w_hs, b_hs;

    assign sel    = grant_q[1];
    assign active = ~rst;

    // Request path is muxed from the owner; the idle master is never forwarded.
    assign s_aw_id    = sel ? m1_aw_id    : m0_aw_id;
    assign s_aw_addr  = sel ? m1_aw_addr  : m0_aw_addr;
    assign s_aw_len   = sel ? m1_aw_len   : m0_aw_len;
    assign s_aw_size  = sel ? m1_aw_size  : m0_aw_size;
    assign s_aw_burst = sel ? m1_aw_burst : m0_aw_burst;
    assign s_aw_valid = active && (state_q == ADDR) && (sel ? m1_aw_valid : m0_aw_valid);
    assign m0_aw_ready = active && (state_q == ADDR) && grant_q[0] && s_aw_ready;
    assign m1_aw_ready = active && (state_q == ADDR) && grant_q[1] && s_aw_ready;

    assign s_w_data   = sel ? m1_w_data : m0_w_data;
    assign s_w_strb   = sel ? m1_w_strb : m0_w_strb;
    assign s_w_last   = sel ? m1_w_last : m0_w_last;
    assign s_w_valid  = active && (state_q == DATA) && (sel ? m1_w_valid : m0_w_valid);
    assign m0_w_ready = active && (state_q == DATA) && grant_q[0] && s_w_ready;
    assign m1_w_ready = active && (state_q == DATA) && grant_q[1] && s_w_ready;

    assign s_b_ready  = active && (state_q == RESP) && (sel ? m1_b_ready : m0_b_ready);
    assign m0_b_valid = active && (state_q == RESP) && grant_q[0] && s_b_valid;
    assign m1_b_valid = active && (state_q == RESP) && grant_q[1] && s_b_valid;
    assign m0_b_id    = grant_q[0] ? s_b_id   : '0;
    assign m0_b_resp  = grant_q[0] ? s_b_resp : '0;
    assign m1_b_id    = grant_q[1] ? s_b_id   : '0;
    assign m1_b_resp  = grant_q[1] ? s_b_resp : '0;

    assign grant = grant_q;

    assign aw_hs = s_aw_valid && s_aw_ready;
    assign w_hs  = s_w_valid && s_w_ready;
    assign b_hs  = s_b_valid && s_b_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        len_d     = len_q;
        beat_d    = beat_q;
        err_len_d = err_len_q;
        case (state_q)
            IDLE: begin
                if (m0_aw_valid && m1_aw_valid) begin
                    grant_d = rr_last_q ? 2'b01 : 2'b10;
                    state_d = ADDR;
                end else if (m0_aw_valid || m1_aw_valid) begin
                    grant_d = m0_aw_valid ? 2'b01 : 2'b10;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d   = s_aw_len;
                    beat_d  = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (s_w_last) begin
                        state_d = RESP;
                    end else if (beat_q == len_q) begin
                        // Burst length exhausted without WLAST: close it out anyway.
                        state_d   = RESP;
                        err_len_d = 1'b1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    rr_last_d = sel;
                    grant_d   = 2'b00;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            err_len_q <= err_len_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_write_arbiter.sv
// ============================================================================
// Module      : tb_axi4_write_arbiter
// Description : Directed scoreboard bench for axi4_write_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi4_write_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 11;
    localparam int SW     = DATA_W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [ID_W-1:0]   m0_aw_id, m1_aw_id, s_aw_id;
    logic [ADDR_W-1:0] m0_aw_addr, m1_aw_addr, s_aw_addr;
    logic [7:0]        m0_aw_len, m1_aw_len, s_aw_len;
    logic [2:0]        m0_aw_size, m1_aw_size, s_aw_size;
    logic [1:0]        m0_aw_burst, m1_aw_burst, s_aw_burst;
    logic              m0_aw_valid, m1_aw_valid, s_aw_valid;
    logic              m0_aw_ready, m1_aw_ready, s_aw_ready;
    logic [DATA_W-1:0] m0_w_data, m1_w_data, s_w_data;
    logic [SW-1:0]     m0_w_strb, m1_w_strb, s_w_strb;
    logic              m0_w_last, m1_w_last, s_w_last;
    logic              m0_w_valid, m1_w_valid, s_w_valid;
    logic              m0_w_ready, m1_w_ready, s_w_ready;
    logic [ID_W-1:0]   m0_b_id, m1_b_id, s_b_id;
    logic [1:0]        m0_b_resp, m1_b_resp, s_b_resp;
    logic              m0_b_valid, m1_b_valid, s_b_valid;
    logic              m0_b_ready, m1_b_ready, s_b_ready;
    logic [1:0]        grant;

    axi4_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .m0_aw_id(m0_aw_id), .m0_aw_addr(m0_aw_addr), .m0_aw_len(m0_aw_len),
        .m0_aw_size(m0_aw_size), .m0_aw_burst(m0_aw_burst), .m0_aw_valid(m0_aw_valid),
        .m0_aw_ready(m0_aw_ready), .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb),
        .m0_w_last(m0_w_last), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
        .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
        .m1_aw_id(m1_aw_id), .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
        .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst), .m1_aw_valid(m1_aw_valid),
        .m1_aw_ready(m1_aw_ready), .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb),
        .m1_w_last(m1_w_last), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
        .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
        .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_valid(s_aw_valid),
        .s_aw_ready(s_aw_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
        .grant(grant)
    );

    typedef struct { int m; logic [ID_W-1:0] id; logic [ADDR_W-1:0] addr; logic [7:0] len; } aw_exp_t;
    typedef struct { int m; logic [DATA_W-1:0] data; } w_exp_t;
    typedef struct { int m; logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;

    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];
    b_exp_t  exp_b[$];

    int checks = 0;
    int errors = 0;

    // master models
    bit                aw_pend [2];
    logic [ID_W-1:0]   mid     [2];
    logic [ADDR_W-1:0] maddr   [2];
    logic [7:0]        mlen    [2];
    bit                last_en [2];
    int                b_hold  [2];
    int                b_cnt   [2];
    logic [DATA_W-1:0] mwq0[$];
    logic [DATA_W-1:0] mwq1[$];

    // slave model
    int          aw_stall, aw_wait, b_delay, b_wait, slv_beat;
    bit          pend, aw_done;
    logic [7:0]  slv_len;
    logic [ID_W-1:0] slv_id;
    logic [1:0]  slv_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int m);
        return (m == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic issue(input int m, input int id, input logic [ADDR_W-1:0] addr, input int len,
                         input int nbeats, input logic [DATA_W-1:0] base, input bit le, input int fwd);
        aw_pend[m] = 1'b1;
        mid[m]     = ID_W'(id);
        maddr[m]   = addr;
        mlen[m]    = 8'(len);
        last_en[m] = le;
        for (int i = 0; i < nbeats; i++) begin
            if (m == 0) mwq0.push_back(base + DATA_W'(i));
            else        mwq1.push_back(base + DATA_W'(i));
        end
        exp_aw.push_back('{m, ID_W'(id), addr, 8'(len)});
        for (int i = 0; i < fwd; i++) exp_w.push_back('{m, base + DATA_W'(i)});
        exp_b.push_back('{m, ID_W'(id), slv_resp});
    endtask

    task automatic drive();
        m0_aw_valid = aw_pend[0]; m0_aw_id = mid[0]; m0_aw_addr = maddr[0]; m0_aw_len = mlen[0];
        m1_aw_valid = aw_pend[1]; m1_aw_id = mid[1]; m1_aw_addr = maddr[1]; m1_aw_len = mlen[1];
        m0_w_valid = (mwq0.size() > 0);
        m0_w_data  = (mwq0.size() > 0) ? mwq0[0] : '0;
        m0_w_last  = last_en[0] && (mwq0.size() == 1);
        m1_w_valid = (mwq1.size() > 0);
        m1_w_data  = (mwq1.size() > 0) ? mwq1[0] : '0;
        m1_w_last  = last_en[1] && (mwq1.size() == 1);
        #1;
        if (s_aw_valid) begin
            s_aw_ready = (aw_wait >= aw_stall);
            aw_wait++;
        end else begin
            s_aw_ready = 1'b0;
            aw_wait    = 0;
        end
        s_b_valid = pend && (b_wait >= b_delay);
        if (pend) b_wait++;
        s_b_id   = slv_id;
        s_b_resp = slv_resp;
        #1;
        if (m0_b_valid) begin m0_b_ready = (b_cnt[0] >= b_hold[0]); b_cnt[0]++; end
        else begin m0_b_ready = 1'b0; b_cnt[0] = 0; end
        if (m1_b_valid) begin m1_b_ready = (b_cnt[1] >= b_hold[1]); b_cnt[1]++; end
        else begin m1_b_ready = 1'b0; b_cnt[1] = 0; end
        #1;
    endtask

    task automatic check_b(input int m, input logic [ID_W-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        chk("b_sb_nonempty", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("b_master", m, e.m);
            chk("b_id", id, e.id);
            chk("b_resp", resp, e.resp);
            chk("b_grant", grant, onehot(m));
        end
    endtask

    task automatic monitor();
        aw_exp_t a;
        w_exp_t  w;
        if (rst)
            chk("rst_outputs_zero", {s_aw_valid, s_w_valid, s_b_ready, m0_aw_ready, m0_w_ready,
                                     m0_b_valid, m1_aw_ready, m1_w_ready, m1_b_valid}, 0);
        if (m0_aw_valid && grant != 2'b01) chk("m0_aw_ready_blocked", m0_aw_ready, 0);
        if (m1_aw_valid && grant != 2'b10) chk("m1_aw_ready_blocked", m1_aw_ready, 0);
        if (s_w_valid || m0_w_ready || m1_w_ready) chk("w_before_aw", aw_done, 1);
        if (s_aw_valid && s_aw_ready) begin
            chk("aw_sb_nonempty", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) begin
                a = exp_aw.pop_front();
                chk("aw_grant", grant, onehot(a.m));
                chk("aw_addr", s_aw_addr, a.addr);
                chk("aw_id", s_aw_id, a.id);
                chk("aw_len", s_aw_len, a.len);
                chk("aw_size_burst", {s_aw_size, s_aw_burst}, 5'b010_01);
            end
            aw_done  = 1'b1;
            slv_len  = s_aw_len;
            slv_id   = s_aw_id;
            slv_beat = 0;
        end
        if (m0_aw_valid && m0_aw_ready) aw_pend[0] = 1'b0;
        if (m1_aw_valid && m1_aw_ready) aw_pend[1] = 1'b0;
        if (s_w_valid && s_w_ready) begin
            chk("w_sb_nonempty", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) begin
                w = exp_w.pop_front();
                chk("w_grant", grant, onehot(w.m));
                chk("w_data", s_w_data, w.data);
                chk("w_strb", s_w_strb, {SW{1'b1}});
            end
            slv_beat++;
            if (s_w_last || slv_beat == int'(slv_len) + 1) begin
                pend   = 1'b1;
                b_wait = 0;
            end
        end
        if (m0_w_valid && m0_w_ready) void'(mwq0.pop_front());
        if (m1_w_valid && m1_w_ready) void'(mwq1.pop_front());
        if (s_b_valid && s_b_ready) begin
            pend    = 1'b0;
            aw_done = 1'b0;
        end
        if (m0_b_valid && m0_b_ready) check_b(0, m0_b_id, m0_b_resp);
        if (m1_b_valid && m1_b_ready) check_b(1, m1_b_id, m1_b_resp);
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int  n;
        bit  idle;
        n    = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            tick();
            n++;
            idle = (exp_aw.size() == 0) && (exp_w.size() == 0) && (exp_b.size() == 0)
                   && (grant == 2'b00) && !pend;
        end
        chk(tag, idle, 1);
    endtask

    initial begin
        rst = 1'b1;
        m0_aw_size = 3'd2; m0_aw_burst = 2'b01; m0_w_strb = '1; m0_b_ready = 1'b0;
        m1_aw_size = 3'd2; m1_aw_burst = 2'b01; m1_w_strb = '1; m1_b_ready = 1'b0;
        s_aw_ready = 1'b0; s_w_ready = 1'b1; s_b_valid = 1'b0; s_b_id = '0; s_b_resp = '0;
        aw_pend = '{0, 0}; mid = '{'0, '0}; maddr = '{'0, '0}; mlen = '{'0, '0};
        last_en = '{1, 1}; b_hold = '{0, 0}; b_cnt = '{0, 0};
        aw_stall = 0; aw_wait = 0; b_delay = 0; b_wait = 0; slv_beat = 0;
        pend = 1'b0; aw_done = 1'b0; slv_len = '0; slv_id = '0; slv_resp = 2'b00;
        drive();

        // reset state
        repeat (3) tick();
        chk("rst_state", dut.state_q, 2'd0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_err_len", dut.err_len_q, 1'b0);
        rst = 1'b0;
        tick();

        // simultaneous requests after reset: 01, 10, 01, 10
        issue(0, 11'h011, 32'h0000_1000, 0, 1, 32'h1111_0000, 1'b1, 1);
        issue(1, 11'h021, 32'h0000_2000, 0, 1, 32'h2222_0000, 1'b1, 1);
        wait_idle("rr_pair1_done", 40);
        issue(0, 11'h012, 32'h0000_1004, 0, 1, 32'h1111_0100, 1'b1, 1);
        issue(1, 11'h022, 32'h0000_2004, 0, 1, 32'h2222_0100, 1'b1, 1);
        wait_idle("rr_pair2_done", 40);

        // single master, zero-wait slave, 4-cycle occupancy
        issue(0, 11'h05A, 32'h0000_0010, 0, 1, 32'hA5A5_A5A5, 1'b1, 1);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_state_addr", dut.state_q, 2'd1);
        tick();
        chk("t1_state_data", dut.state_q, 2'd2);
        tick();
        chk("t1_state_resp", dut.state_q, 2'd3);
        tick();
        chk("t1_state_idle", dut.state_q, 2'd0);
        chk("t1_grant_clear", grant, 2'b00);
        chk("t1_b_done", exp_b.size(), 0);

        // m1 waits through an m0 4-beat burst
        issue(0, 11'h031, 32'h0000_3000, 3, 4, 32'h3333_0000, 1'b1, 4);
        tick();
        tick();
        issue(1, 11'h041, 32'h0000_4000, 0, 1, 32'h4444_0000, 1'b1, 1);
        wait_idle("burst_then_m1_done", 60);

        // slave and master stalls
        aw_stall = 3; b_delay = 5; b_hold[0] = 2;
        issue(0, 11'h051, 32'h0000_5000, 1, 2, 32'h5555_0000, 1'b1, 2);
        wait_idle("stall_done", 80);
        aw_stall = 0; b_delay = 0; b_hold[0] = 0;
        chk("err_len_clean", dut.err_len_q, 1'b0);

        // missing WLAST: closes after len+1 beats and flags err_len
        slv_resp = 2'b10;
        issue(0, 11'h061, 32'h0000_6000, 1, 3, 32'h6666_0000, 1'b0, 2);
        wait_idle("no_last_done", 60);
        mwq0.delete();
        last_en[0] = 1'b1;
        slv_resp   = 2'b00;
        chk("err_len_set", dut.err_len_q, 1'b1);

        // reset in the middle of a data burst
        begin
            int n;
            n = 0;
            issue(0, 11'h071, 32'h0000_7000, 3, 4, 32'h7777_0000, 1'b1, 4);
            while (dut.state_q != 2'd2 && n < 20) begin
                tick();
                n++;
            end
            chk("reach_data", dut.state_q, 2'd2);
        end
        tick();
        rst = 1'b1;
        aw_pend = '{0, 0};
        mwq0.delete();
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
        pend = 1'b0; aw_done = 1'b0;
        tick();
        chk("mid_rst_state", dut.state_q, 2'd0);
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_err_len", dut.err_len_q, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        issue(1, 11'h081, 32'h0000_8000, 1, 2, 32'h8888_0000, 1'b1, 2);
        wait_idle("post_rst_m1_done", 40);
        chk("final_err_len", dut.err_len_q, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_write_arbiter.md
AXI4_WRITE_ARBITER -- requirements
Module: axi4_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AW address width.
REQ-002 SHALL have parameter DATA_W, default 32: W data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter ID_W, default 11: AW/B ID width, passed through unmodified.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports m0_aw_{id,addr,len,size,burst,valid}  in  ID_W/ADDR_W/8/3/2/1  master-0 write-address request.
REQ-007 SHALL have port m0_aw_ready  out  1  master-0 address accepted.
REQ-008 SHALL have ports m0_w_{data,strb,last,valid}  in  DATA_W/DATA_W/8/1/1  master-0 write data.
REQ-009 SHALL have port m0_w_ready  out  1  master-0 data accepted.
REQ-010 SHALL have ports m0_b_{id,resp,valid}  out  ID_W/2/1  master-0 write response.
REQ-011 SHALL have port m0_b_ready  in  1  master-0 response accepted.
REQ-012 SHALL have ports m1_* identical to REQ-006..011 for master 1.
REQ-013 SHALL have ports s_aw_*, s_w_*, s_b_* mirroring one master bundle with directions reversed, toward the single shared slave.
REQ-014 SHALL have port grant  out  2  one-hot current owner (00 = none), for monitors.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, DATA, RESP; exactly one write transaction in flight at a time.
REQ-016 IDLE: if any m*_aw_valid, SHALL register grant and enter ADDR next cycle; no combinational path from m*_aw_valid to s_aw_valid.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, the master not served last wins; after reset, master 0 has priority.
REQ-018 Single requester SHALL be granted regardless of round-robin pointer.
REQ-019 ADDR: s_aw_* SHALL equal granted master's aw_* combinationally; granted m*_aw_ready = s_aw_ready; non-granted aw_ready = 0; on s_aw_valid && s_aw_ready go to DATA.
REQ-020 DATA: s_w_* SHALL mux from granted master; granted m*_w_ready = s_w_ready; on handshake with w_last = 1 go to RESP.
REQ-021 DATA SHALL count beats; if beat count reaches captured aw_len+1 without w_last, SHALL still enter RESP and assert sticky err_len flag (internal, visible to bench by hierarchy) until reset.
REQ-022 RESP: s_b_ready SHALL equal granted m*_b_ready; s_b_* SHALL route only to granted master; non-granted b_valid = 0.
REQ-023 On s_b_valid && s_b_ready SHALL update round-robin pointer to the just-served master, clear grant, return to IDLE.
REQ-024 IDLE-to-ADDR SHALL take 1 cycle; minimum transaction occupancy is 4 cycles (IDLE, ADDR, DATA, RESP) for a 1-beat burst with zero-wait slave.
REQ-025 W data presented by a master before its AW grant SHALL be held off (w_ready = 0), never forwarded.
REQ-026 Outside ADDR/DATA/RESP respectively, s_aw_valid, s_w_valid, s_b_ready SHALL be 0.
REQ-027 A master deasserting aw_valid while in ADDR is an AXI violation; arbiter SHALL remain in ADDR (no abort).

Reset
REQ-028 While rst = 1 at posedge: state = IDLE, grant = 00, RR pointer favours master 0, beat counter = 0, err_len = 0.
REQ-029 All ready/valid outputs SHALL be 0 during reset; reset mid-transaction SHALL abandon it with no further handshakes.

Verification
REQ-030 m0 only, AW len=0 addr=0x10, W data=0xA5A5A5A5 last=1, slave zero-wait, b_resp=00 -> grant=01, m0_b_valid with id echoed, return IDLE after 4 cycles.
REQ-031 m0 and m1 aw_valid same cycle after reset -> m0 served first, then m1; repeated simultaneous requests alternate 01,10,01,10.
REQ-032 m1 holds aw_valid while m0 is in DATA with 4-beat burst (len=3) -> m1_aw_ready stays 0 until m0 B handshake; slave sees exactly 4 beats from m0.
REQ-033 Slave stalls: s_aw_ready low 3 cycles, s_b_valid delayed 5 cycles, m0_b_ready low 2 cycles -> no beat lost or duplicated, grant held throughout.
REQ-034 len=1 burst with w_last never asserted -> RESP after 2 beats, err_len = 1.
REQ-035 rst asserted during DATA -> next cycle IDLE, grant=00, all valids/readys 0; fresh m1 request then completes normally.
